vdic_alu_stack: RTL and testbench

Parametrised operand-stack ALU for the VDIC DUT family: accepts a stream of parity-protected data and command words and stacks data operands. On each command it folds the whole stack with AND/OR/XOR/ADD/SUB and queues a {status, result} entry into an output FIFO. Next generation of the 2022 DUT: width, stack depth and FIFO depth are generic, and a selectable full-FIFO policy is added.

---
 rtl/vdic_alu_pkg.sv | 41 ++++
 rtl/vdic_alu_stack_if.sv | 22 ++
 rtl/vdic_alu_fifo.sv | 54 +++++
 rtl/vdic_alu_stack.sv | 185 ++++++++++++++++++
 tb/tb_vdic_alu_stack.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdic_alu_pkg.sv
// Shared types for the VDIC operand-stack ALU: opcodes, status bits, FSM states
// and small status helpers.
package vdic_alu_pkg;

    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_AND = 8'h01,
        OP_OR  = 8'h02,
        OP_XOR = 8'h03,
        OP_ADD = 8'h10,
        OP_SUB = 8'h20
    } operation_t;

    typedef enum logic [7:0] {
        ST_NO_ERROR             = 8'h00,
        ST_MISSING_DATA         = 8'h01,
        ST_DATA_STACK_OVERFLOW  = 8'h02,
        ST_OUTPUT_FIFO_OVERFLOW = 8'h04,
        ST_DATA_PARITY_ERROR    = 8'h20,
        ST_COMMAND_PARITY_ERROR = 8'h40,
        ST_INVALID_COMMAND      = 8'h80
    } stat_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } alu_state_t;

    function automatic logic [7:0] stat_if(input logic cond, input stat_t s);
        return cond ? 8'(s) : 8'h00;
    endfunction

    function automatic logic is_known_op(input logic [7:0] code);
        case (code)
            OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vdic_alu_stack_if.sv
// Input word stream and output entry stream of the VDIC operand-stack ALU.
interface vdic_alu_stack_if #(parameter int DATA_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic              in_is_cmd;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [7:0]        out_status;

    modport master (
        output in_valid, in_is_cmd, in_data, in_parity, out_ready,
        input  in_ready, out_valid, out_result, out_status
    );

    modport slave (
        input  in_valid, in_is_cmd, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_result, out_status
    );
endinterface

// File: rtl/vdic_alu_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module vdic_alu_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == (PTR_W + 1)'(DEPTH));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end
endmodule

// File: rtl/vdic_alu_stack.sv
// Operand-stack ALU: stacks parity-checked operands, folds them on a command and
// queues {status, result}. Define VDIC_ALU_FIFO_BACKPRESSURE_EN to stall on a full FIFO.
module vdic_alu_stack
    import vdic_alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 9,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    vdic_alu_stack_if.slave  bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    typedef struct packed {
        logic [7:0]        stat;
        logic [DATA_W-1:0] result;
    } entry_t;

    alu_state_t        state_r, state_nxt_s;
    logic [DATA_W-1:0] stack_r [STACK_DEPTH];
    logic [CNT_W-1:0]  count_r, idx_r;
    logic              perr_r, ovf_r;
    operation_t        op_r;
    logic [7:0]        stat_r;
    logic [DATA_W-1:0] acc_r;

    logic              accept_s, word_perr_s, is_nop_s, push_s, last_operand_s;
    logic [7:0]        opcode_s, cmd_err_s, cmd_stat_s;
    logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s, fifo_block_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    entry_t            push_entry_s, head_s;

    function automatic logic [DATA_W-1:0] alu_fold(input operation_t op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return a;
        endcase
    endfunction

    assign bus.in_ready   = (state_r == S_IDLE);
    assign accept_s       = bus.in_valid && bus.in_ready;
    assign opcode_s       = bus.in_data[7:0];
    assign word_perr_s    = ((^bus.in_data) != bus.in_parity);
    assign is_nop_s       = !word_perr_s && (opcode_s == OP_NOP);
    assign push_s         = accept_s && !bus.in_is_cmd && !word_perr_s &&
                            (count_r != CNT_W'(STACK_DEPTH));
    assign last_operand_s = (idx_r == count_r - CNT_W'(1));

    // Missing data is only reported when nothing more specific went wrong.
    assign cmd_err_s  = stat_if(word_perr_s, ST_COMMAND_PARITY_ERROR) |
                        stat_if(!is_known_op(opcode_s), ST_INVALID_COMMAND) |
                        stat_if(perr_r, ST_DATA_PARITY_ERROR) |
                        stat_if(ovf_r, ST_DATA_STACK_OVERFLOW);
    assign cmd_stat_s = cmd_err_s |
                        stat_if((cmd_err_s == 8'h00) && (count_r < CNT_W'(2)), ST_MISSING_DATA);

    assign fifo_pop_s   = !fifo_empty_s && bus.out_ready;
    assign fifo_block_s = fifo_full_s && !fifo_pop_s;

    // Next-state and FIFO write decision.
    always_comb begin
        state_nxt_s = state_r;
        fifo_push_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s && bus.in_is_cmd && !is_nop_s) begin
                    state_nxt_s = (cmd_stat_s != 8'h00) ? S_WRITE : S_EXEC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (last_operand_s) state_nxt_s = S_WRITE;
                else                state_nxt_s = S_EXEC;
            end
            S_WRITE: begin
`ifdef VDIC_ALU_FIFO_BACKPRESSURE_EN
                if (!fifo_block_s) begin
                    fifo_push_s = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WRITE;
                end
`else
                fifo_push_s = !fifo_block_s;
                state_nxt_s = S_IDLE;
`endif
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand storage; occupancy is tracked by count_r, so no reset needed here.
    always_ff @(posedge clk) begin
        if (push_s) stack_r[count_r] <= bus.in_data;
    end

    // Stack bookkeeping, sticky input errors and the fold accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            idx_r   <= '0;
            perr_r  <= 1'b0;
            ovf_r   <= 1'b0;
            op_r    <= OP_NOP;
            stat_r  <= 8'h00;
            acc_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s && !bus.in_is_cmd) begin
                        if (word_perr_s)  perr_r  <= 1'b1;
                        else if (push_s)  count_r <= count_r + CNT_W'(1);
                        else              ovf_r   <= 1'b1;
                    end else if (accept_s && !is_nop_s) begin
                        op_r   <= operation_t'(opcode_s);
                        stat_r <= cmd_stat_s;
                        acc_r  <= (cmd_stat_s == 8'h00) ? stack_r[0] : '0;
                        idx_r  <= CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    acc_r <= alu_fold(op_r, acc_r, stack_r[idx_r]);
                    idx_r <= idx_r + CNT_W'(1);
                end
                S_WRITE: begin
                    if (state_nxt_s == S_IDLE) begin
                        count_r <= '0;
                        perr_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VDIC_ALU_FIFO_BACKPRESSURE_EN
    assign push_entry_s = '{stat: stat_r, result: acc_r};
`else
    logic fovf_r;

    // Remembers a dropped entry until the next entry is actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     fovf_r <= 1'b0;
        else if (state_r == S_WRITE) fovf_r <= fifo_block_s;
    end

    assign push_entry_s = '{stat: stat_r | stat_if(fovf_r, ST_OUTPUT_FIFO_OVERFLOW),
                            result: acc_r};
`endif

    vdic_alu_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (push_entry_s),
        .pop       (fifo_pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.out_valid  = (fifo_count_s != '0);
    assign bus.out_result = fifo_empty_s ? '0 : head_s.result;
    assign bus.out_status = fifo_empty_s ? 8'h00 : head_s.stat;
endmodule

// File: tb/tb_vdic_alu_stack.sv
// Directed bench for vdic_alu_stack with a queue-based reference model and pinned literals.
// Expectations follow VDIC_ALU_FIFO_BACKPRESSURE_EN when it is defined.
module tb_vdic_alu_stack;
    localparam int DW = 16;
    localparam int SD = 9;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vdic_alu_stack_if #(.DATA_W(DW)) bus();

    vdic_alu_stack #(.DATA_W(DW), .STACK_DEPTH(SD), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    logic [DW-1:0] m_stk[$];
    bit          m_perr = 1'b0, m_ovf = 1'b0, m_fovf = 1'b0;
    logic [23:0] m_last = 24'h0;
    logic [23:0] held = 24'h0;
    logic [23:0] e;
    bit          hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: status and folded result for a command, from the current model stack.
    function automatic logic [23:0] model_eval(input logic [7:0] op, input bit bad);
        logic [7:0]    st = 8'h00;
        logic [DW-1:0] acc = '0;
        bit            known;
        known = (op == 8'h00) || (op == 8'h01) || (op == 8'h02) || (op == 8'h03) ||
                (op == 8'h10) || (op == 8'h20);
        if (bad)    st |= 8'h40;
        if (!known) st |= 8'h80;
        if (m_perr) st |= 8'h20;
        if (m_ovf)  st |= 8'h02;
        if (st == 8'h00 && m_stk.size() < 2) st = 8'h01;
        if (st == 8'h00) begin
            acc = m_stk[0];
            for (int i = 1; i < m_stk.size(); i++) begin
                case (op)
                    8'h01:   acc = acc & m_stk[i];
                    8'h02:   acc = acc | m_stk[i];
                    8'h03:   acc = acc ^ m_stk[i];
                    8'h10:   acc = acc + m_stk[i];
                    default: acc = acc - m_stk[i];
                endcase
            end
        end
        return {st, acc};
    endfunction

    task automatic model_accept(input bit cmd, input logic [DW-1:0] d, input bit bad);
        if (!cmd) begin
            if (bad)                    m_perr = 1'b1;
            else if (m_stk.size() == SD) m_ovf = 1'b1;
            else                        m_stk.push_back(d);
        end else if (!(d[7:0] == 8'h00 && !bad)) begin
            m_last = model_eval(d[7:0], bad);
`ifdef VDIC_ALU_FIFO_BACKPRESSURE_EN
            exp_q.push_back(m_last);
`else
            if (exp_q.size() >= FD) begin
                m_fovf = 1'b1;
            end else begin
                if (m_fovf) m_last[23:16] = m_last[23:16] | 8'h04;
                exp_q.push_back(m_last);
                m_fovf = 1'b0;
            end
`endif
            m_stk.delete();
            m_perr = 1'b0;
            m_ovf  = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input bit cmd, input logic [DW-1:0] d, input bit bad);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=0, expected 1");
        end else begin
            bus.in_valid  = 1'b1;
            bus.in_is_cmd = cmd;
            bus.in_data   = d;
            bus.in_parity = (^d) ^ bad;
            model_accept(cmd, d, bad);
            @(negedge clk);
            bus.in_valid  = 1'b0;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        send(1'b0, d, 1'b0);
    endtask

    task automatic op(input logic [7:0] code);
        send(1'b1, {8'h00, code}, 1'b0);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1 bus.out_ready = v;
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Compare process: every popped entry against the model, and head stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) check("hold_stable", {bus.out_status, bus.out_result}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_entry: got %0h, expected no entry",
                             {bus.out_status, bus.out_result});
                end else begin
                    e = exp_q.pop_front();
                    check("entry", {bus.out_status, bus.out_result}, e);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.out_status, bus.out_result};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_is_cmd = 1'b0;
        bus.in_data   = '0;
        bus.in_parity = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check("rst_in_ready",   bus.in_ready,   1);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_status", bus.out_status, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // AND with latency check, then ADD of the same operands.
        push(16'h0F0F); push(16'h00FF); op(8'h01);
        check("model_and", m_last, 24'h00000F);
        check("lat_k_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_k1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_k2_valid", bus.out_valid, 1);
        check("lat_k2_entry", {bus.out_status, bus.out_result}, 24'h00000F);
        push(16'h0F0F); push(16'h00FF); op(8'h10);
        check("model_add", m_last, 24'h00100E);
        drain();

        // SUB chain, then SUB with an empty stack.
        push(16'h0005); push(16'h0007); push(16'h0001); op(8'h20);
        check("model_sub", m_last, 24'h00FFFD);
        op(8'h20);
        check("model_missing", m_last, 24'h010000);
        drain();

        // NOP leaves the stack alone.
        push(16'h0003); push(16'h0005); op(8'h00); op(8'h02);
        check("model_nop_or", m_last, 24'h000007);
        drain();

        // Stack overflow, then a normal command on the cleared stack.
        for (int i = 1; i <= 10; i++) push(16'(i * 16'h0101));
        op(8'h03);
        check("model_stack_ovf", m_last, 24'h020000);
        push(16'h00F0); push(16'h0FF0); op(8'h01);
        check("model_after_ovf", m_last, 24'h0000F0);
        drain();

        // Data parity, invalid opcode, command parity.
        send(1'b0, 16'h0003, 1'b1); push(16'h0004); op(8'h10);
        check("model_data_perr", m_last, 24'h200000);
        push(16'h0004); push(16'h0001); op(8'hFE);
        check("model_invalid", m_last, 24'h800000);
        send(1'b1, 16'h0010, 1'b1);
        check("model_cmd_perr", m_last, 24'h400000);
        drain();

        // Five commands into a stalled FIFO of four.
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) begin
            push(16'(i + 1)); push(16'(i + 2)); op(8'h10);
            if (i == 0) check("model_fill0", m_last, 24'h000003);
        end
        repeat (4) @(negedge clk);
`ifdef VDIC_ALU_FIFO_BACKPRESSURE_EN
        check("stall_in_ready", bus.in_ready, 0);
`else
        check("stall_in_ready", bus.in_ready, 1);
`endif
        check("stall_head", {bus.out_status, bus.out_result}, 24'h000003);
        set_ready(1'b1);
        drain();
        push(16'h0001); push(16'h0002); op(8'h10);
`ifdef VDIC_ALU_FIFO_BACKPRESSURE_EN
        check("model_after_full", m_last, 24'h000003);
`else
        check("model_after_full", m_last, 24'h040003);
`endif
        drain();

        // Reset during EXEC with one entry queued.
        set_ready(1'b0);
        push(16'h0002); push(16'h0004); op(8'h02);
        push(16'h0001); push(16'h0002); push(16'h0003); op(8'h10);
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",   bus.in_ready,   1);
        check("mid_rst_out_valid",  bus.out_valid,  0);
        check("mid_rst_out_result", bus.out_result, 0);
        check("mid_rst_out_status", bus.out_status, 0);
        exp_q.delete();
        m_stk.delete();
        m_perr = 1'b0;
        m_ovf  = 1'b0;
        m_fovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_ready(1'b1);
        op(8'h10);
        check("model_post_rst", m_last, 24'h010000);
        drain();

        check("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
